// File: rtl/rv_pkg.sv
// rv_pkg
//   Shared constants and types for the unified memory port arbiter.
//   XLEN        : default data width of memory and requester buses
//   arb_state_e : arbiter FSM state encoding
//   MEM_BE_ALL  : full-word byte-enable mask used for instruction fetches
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [XLEN/8-1:0] MEM_BE_ALL = '1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Counts BUSY cycles that pass without a memory handshake and flags the
//   cycle in which the configured limit is reached.
//   Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : arbiter is granting a request this cycle (clears the count)
//   busy      : arbiter is in a BUSY state
//   ready     : memory handshake this cycle
//   expire    : limit reached in this BUSY cycle without ready
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (busy && !ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of BUSY cycles already completed without ready,
  // so the limit is hit during the TIMEOUT_CYCLES-th such cycle.
  assign expire = busy && !ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF) and the
//   data stage (MEM). Data has fixed priority. The memory-side request is
//   latched and held until mem_ready; read data is registered and returned
//   to the owning stage with a one-cycle valid pulse.
//   Optional watchdog: define MEM_ARB_TIMEOUT_EN.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_req/if_addr/if_flush        : fetch request, address, pc redirect
//   if_valid/if_rdata/if_stall     : fetch response pulse, data, stall
//   d_req/d_we/d_addr/d_wdata/d_be : data request fields
//   d_valid/d_rdata/d_stall        : data response pulse, load data, stall
//   mem_req/we/addr/wdata/be       : latched memory request
//   mem_ready/mem_rdata            : memory handshake and read data
//   err_timeout                    : sticky watchdog error
module mem_port_arbiter #(
  parameter int XLEN           = rv_pkg::XLEN,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_valid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              err_timeout
);

  import rv_pkg::*;

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN/8-1:0] mem_be_q, mem_be_d;
  logic              if_valid_q, if_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]   d_rdata_q, d_rdata_d;
  logic              discard_q, discard_d;
  logic              err_q, err_d;
  logic              expire;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_start;
  logic wd_busy;

  assign wd_start = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);
  assign wd_busy  = (state_q != ARB_IDLE);

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .start (wd_start),
    .busy  (wd_busy),
    .ready (mem_ready),
    .expire(expire)
  );
`else
  // No watchdog: the comparison is constant false for any legal limit.
  assign expire = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    discard_d   = discard_q;
    err_d       = err_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (d_req) begin
          state_d     = ARB_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end else if (if_req && !if_flush) begin
          state_d    = ARB_BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_be_d   = (XLEN/8)'(MEM_BE_ALL);
        end
      end

      ARB_BUSY_I: begin
        if (mem_ready || expire) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          // A redirect seen earlier or in this very cycle drops the result.
          if (!discard_q && !if_flush) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
          if (!mem_ready) begin
            err_d = 1'b1;
          end
        end else if (if_flush) begin
          discard_d = 1'b1;
        end
      end

      ARB_BUSY_D: begin
        if (mem_ready || expire) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          d_valid_d = 1'b1;
          d_rdata_d = mem_ready ? mem_rdata : '0;
          if (!mem_ready) begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      discard_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      discard_q   <= discard_d;
      err_q       <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign if_valid    = if_valid_q;
  assign if_rdata    = if_rdata_q;
  assign d_valid     = d_valid_q;
  assign d_rdata     = d_rdata_q;
  assign err_timeout = err_q;

  assign if_stall = if_req & ~if_valid_q;
  assign d_stall  = d_req & ~d_valid_q;

endmodule
